// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read-port bundle between the byte FIFO and its UART consumer
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;

  // master: the consumer that pops bytes; slave: the FIFO read side
  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the read side of a FIFO and serializes them as UART frames
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic           rd_clk,
  input  logic           reset_n,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int            TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    index_q, index_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          fifo_rd_q, fifo_rd_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          timer_done;

  assign timer_done   = (timer_q == TMAX);
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign fifo.fifo_rd = fifo_rd_q;

  always_ff @(posedge rd_clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      index_q      <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      fifo_rd_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      index_q      <= index_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      fifo_rd_q    <= fifo_rd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    index_d  = index_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    unique case (state_q)
      IDLE: begin
        if (enable && !fifo.fifo_empty) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d  = fifo.fifo_data;
        parity_d = ^fifo.fifo_data;
        index_d  = 3'd0;
        state_d  = START;
      end
      START: begin
        if (timer_done) state_d = DATA;
        else            timer_d = timer_q + TW'(1);
      end
      DATA: begin
        if (timer_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (index_q == 3'd7) begin
            index_d = 3'd0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            index_d = index_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PARITY: begin
        if (timer_done) state_d = STOP;
        else            timer_d = timer_q + TW'(1);
      end
      STOP: begin
        if (timer_done) state_d = IDLE;
        else            timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase

    fifo_rd_d    = (state_d == POP);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == STOP) && (timer_d == TMAX);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench for fifo_uart_tx in 8N1/4, 8E1/4 and 8N1/2 configurations
module tb_fifo_uart_tx;

  logic rd_clk = 1'b0;
  logic reset_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;

  int vectors = 0;
  int miscompares = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_uart_tx_if bus0 ();
  fifo_uart_tx_if bus1 ();
  fifo_uart_tx_if bus2 ();

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .rd_clk(rd_clk), .reset_n(reset_n), .enable(en0), .fifo(bus0),
    .tx(tx0), .busy(busy0), .frame_done(done0));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .rd_clk(rd_clk), .reset_n(reset_n), .enable(en1), .fifo(bus1),
    .tx(tx1), .busy(busy1), .frame_done(done1));
  fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) dut2 (
    .rd_clk(rd_clk), .reset_n(reset_n), .enable(en2), .fifo(bus2),
    .tx(tx2), .busy(busy2), .frame_done(done2));

  // FIFO models: write side driven by the stimulus, read side by the pop strobe
  logic [7:0] mem0 [8], mem1 [8], mem2 [8];
  int wr0 = 0, wr1 = 0, wr2 = 0;
  int rd0 = 0, rd1 = 0, rd2 = 0;
  int bad0 = 0, bad1 = 0, bad2 = 0;

  assign bus0.fifo_empty = (wr0 == rd0);
  assign bus1.fifo_empty = (wr1 == rd1);
  assign bus2.fifo_empty = (wr2 == rd2);

  always @(posedge rd_clk) if (bus0.fifo_rd) begin
    if (wr0 == rd0) bad0 <= bad0 + 1;
    bus0.fifo_data <= mem0[rd0[2:0]];
    rd0 <= rd0 + 1;
  end
  always @(posedge rd_clk) if (bus1.fifo_rd) begin
    if (wr1 == rd1) bad1 <= bad1 + 1;
    bus1.fifo_data <= mem1[rd1[2:0]];
    rd1 <= rd1 + 1;
  end
  always @(posedge rd_clk) if (bus2.fifo_rd) begin
    if (wr2 == rd2) bad2 <= bad2 + 1;
    bus2.fifo_data <= mem2[rd2[2:0]];
    rd2 <= rd2 + 1;
  end

  task automatic push(input int k, input logic [7:0] b);
    case (k)
      0: begin mem0[wr0[2:0]] = b; wr0++; end
      1: begin mem1[wr1[2:0]] = b; wr1++; end
      default: begin mem2[wr2[2:0]] = b; wr2++; end
    endcase
  endtask

  task automatic set_en(input int k, input logic v);
    case (k)
      0: en0 = v;
      1: en1 = v;
      default: en2 = v;
    endcase
  endtask

  // {tx, busy, fifo_rd, frame_done}
  function automatic logic [3:0] outs(input int k);
    case (k)
      0:       return {tx0, busy0, bus0.fifo_rd, done0};
      1:       return {tx1, busy1, bus1.fifo_rd, done1};
      default: return {tx2, busy2, bus2.fifo_rd, done2};
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int k, input int n, input string tag);
    logic [3:0] o;
    for (int c = 0; c < n; c++) begin
      @(negedge rd_clk);
      o = outs(k);
      chk1({tag, "/tx"}, o[3], 1'b1);
      chk1({tag, "/busy"}, o[2], 1'b0);
      chk1({tag, "/rd"}, o[1], 1'b0);
      chk1({tag, "/done"}, o[0], 1'b0);
    end
  endtask

  task automatic wait_pop(input int k, input string tag);
    logic [3:0] o;
    o = 4'h0;
    for (int n = 0; n < 200; n++) begin
      @(negedge rd_clk);
      o = outs(k);
      if (o[1]) break;
    end
    chk1({tag, "/pop"}, o[1], 1'b1);
    chk1({tag, "/pop_tx"}, o[3], 1'b1);
    chk1({tag, "/pop_busy"}, o[2], 1'b1);
  endtask

  // One IDLE cycle then the POP cycle: three tx-high cycles between frames with LOAD
  task automatic gap_pop(input int k, input string tag);
    logic [3:0] o;
    @(negedge rd_clk);
    o = outs(k);
    chk1({tag, "/gap_tx"}, o[3], 1'b1);
    chk1({tag, "/gap_busy"}, o[2], 1'b0);
    chk1({tag, "/gap_rd"}, o[1], 1'b0);
    @(negedge rd_clk);
    o = outs(k);
    chk1({tag, "/pop"}, o[1], 1'b1);
    chk1({tag, "/pop_tx"}, o[3], 1'b1);
  endtask

  // Call just after the POP cycle was observed. ev_kind 1 drops enable, 2 pulses reset.
  task automatic frame(input int k, input logic [7:0] b, input int cpb, input bit par,
                       input int ev_bit, input int ev_kind, input string tag);
    logic [3:0] o;
    logic e;
    int nb;
    nb = par ? 11 : 10;
    @(negedge rd_clk);
    o = outs(k);
    chk1({tag, "/load_tx"}, o[3], 1'b1);
    chk1({tag, "/load_rd"}, o[1], 1'b0);
    chk1({tag, "/load_busy"}, o[2], 1'b1);
    for (int i = 0; i < nb; i++) begin
      if (i == 0)                e = 1'b0;
      else if (i <= 8)           e = b[i-1];
      else if (par && i == 9)    e = ^b;
      else                       e = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        @(negedge rd_clk);
        o = outs(k);
        chk1($sformatf("%s/bit%0d_c%0d_tx", tag, i, c), o[3], e);
        chk1($sformatf("%s/bit%0d_c%0d_busy", tag, i, c), o[2], 1'b1);
        chk1($sformatf("%s/bit%0d_c%0d_rd", tag, i, c), o[1], 1'b0);
        chk1($sformatf("%s/bit%0d_c%0d_done", tag, i, c), o[0],
             (i == nb - 1) && (c == cpb - 1));
        if (i == ev_bit && c == 0) begin
          if (ev_kind == 1) begin
            set_en(k, 1'b0);
          end else if (ev_kind == 2) begin
            reset_n = 1'b0;
            @(negedge rd_clk);
            o = outs(k);
            chk1({tag, "/rst_tx"}, o[3], 1'b1);
            chk1({tag, "/rst_busy"}, o[2], 1'b0);
            chk1({tag, "/rst_rd"}, o[1], 1'b0);
            chk1({tag, "/rst_done"}, o[0], 1'b0);
            reset_n = 1'b1;
            return;
          end
        end
      end
    end
  endtask

  initial begin
    logic [3:0] o;

    repeat (2) @(negedge rd_clk);
    for (int k = 0; k < 3; k++) begin
      o = outs(k);
      chk1($sformatf("reset%0d/tx", k), o[3], 1'b1);
      chk1($sformatf("reset%0d/busy", k), o[2], 1'b0);
      chk1($sformatf("reset%0d/rd", k), o[1], 1'b0);
      chk1($sformatf("reset%0d/done", k), o[0], 1'b0);
    end
    reset_n = 1'b1;
    idle_check(0, 2, "post_reset");

    // single 8N1 frame of A5
    push(0, 8'hA5);
    set_en(0, 1'b1);
    wait_pop(0, "t1");
    frame(0, 8'hA5, 4, 1'b0, -1, 0, "t1");
    idle_check(0, 3, "t1_end");
    set_en(0, 1'b0);

    // full FIFO drained back-to-back
    for (int j = 0; j < 8; j++) push(0, 8'(j));
    set_en(0, 1'b1);
    wait_pop(0, "t2_0");
    frame(0, 8'h00, 4, 1'b0, -1, 0, "t2_0");
    for (int j = 1; j < 8; j++) begin
      gap_pop(0, $sformatf("t2_%0d", j));
      frame(0, 8'(j), 4, 1'b0, -1, 0, $sformatf("t2_%0d", j));
    end
    idle_check(0, 3, "t2_end");
    set_en(0, 1'b0);

    // even parity configuration
    push(1, 8'h01);
    push(1, 8'h03);
    set_en(1, 1'b1);
    wait_pop(1, "t3_a");
    frame(1, 8'h01, 4, 1'b1, -1, 0, "t3_a");
    gap_pop(1, "t3_b");
    frame(1, 8'h03, 4, 1'b1, -1, 0, "t3_b");
    idle_check(1, 2, "t3_end");

    // minimum bit period
    push(2, 8'hFF);
    set_en(2, 1'b1);
    wait_pop(2, "t6");
    frame(2, 8'hFF, 2, 1'b0, -1, 0, "t6");
    idle_check(2, 2, "t6_end");

    // enable gating and enable dropped during D3
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    idle_check(0, 10, "t4_hold");
    set_en(0, 1'b1);
    @(negedge rd_clk);
    o = outs(0);
    chk1("t4/pop_next", o[1], 1'b1);
    frame(0, 8'h11, 4, 1'b0, 4, 1, "t4");
    idle_check(0, 12, "t4_nopop");

    // reset during D5 aborts; next queued byte goes out cleanly
    set_en(0, 1'b1);
    wait_pop(0, "t5_a");
    frame(0, 8'h22, 4, 1'b0, 6, 2, "t5_a");
    wait_pop(0, "t5_b");
    frame(0, 8'h33, 4, 1'b0, -1, 0, "t5_b");
    idle_check(0, 3, "t5_end");
    chkn("t5/fifo_drained", wr0 - rd0, 0);

    chkn("pop_while_empty", bad0 + bad1 + bad2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
